// File: rtl/hpdcache_victim_sel_multi.sv
// Victim-way selector for the HPDcache refill path: one-hot victim chosen combinationally from
// per-way directory state under a runtime-selectable policy, with way locking and eviction stats.
module hpdcache_victim_sel_multi #(
  parameter int unsigned SETS       = 128,
  parameter int unsigned WAYS       = 4,
  parameter int unsigned LFSR_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [1:0]              mode_i,
  input  logic                    sel_victim_i,
  input  logic [$clog2(SETS)-1:0] sel_set_i,
  input  logic [WAYS-1:0]         sel_dir_valid_i,
  input  logic [WAYS-1:0]         sel_dir_dirty_i,
  input  logic [WAYS-1:0]         sel_dir_fetch_i,
  input  logic [WAYS-1:0]         lock_i,
  input  logic                    cnt_clr_i,
  output logic [WAYS-1:0]         sel_victim_way_o,
  output logic                    sel_none_o,
  output logic                    sel_dirty_o,
  output logic [CNT_WIDTH-1:0]    dirty_evict_cnt_o
);

  localparam int unsigned IdxW = $clog2(WAYS);

  localparam logic [1:0] ModeRandom     = 2'd0;
  localparam logic [1:0] ModeRoundRobin = 2'd1;

  // Feedback tap masks (bit = tap - 1) for the supported LFSR widths.
  localparam logic [31:0] TapsAll = (LFSR_WIDTH == 8)  ? 32'h0000_00B8 :
                                    (LFSR_WIDTH == 16) ? 32'h0000_B400 :
                                                         32'h8020_0003;
  localparam logic [LFSR_WIDTH-1:0] Taps = TapsAll[LFSR_WIDTH-1:0];

  typedef logic [WAYS-1:0] way_vec_t;
  typedef logic [IdxW-1:0] way_idx_t;

  function automatic way_vec_t first_oh(input way_vec_t v);
    way_vec_t r;
    r = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic way_idx_t oh_to_idx(input way_vec_t v);
    way_idx_t r;
    r = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (v[i]) r = way_idx_t'(i);
    end
    return r;
  endfunction

  logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  way_idx_t              ptr_q [SETS];
  way_idx_t              ptr_d;
  logic                  ptr_we;

  way_vec_t elig, unused_v, clean_v, dirty_v, cand_oh, victim;
  way_idx_t cand_idx;
  logic     cand_en, from_unused, accept, lfsr_fb;

  always_comb begin
    elig     = ~sel_dir_fetch_i & ~lock_i;
    unused_v = elig & ~sel_dir_valid_i;
    clean_v  = elig & sel_dir_valid_i & ~sel_dir_dirty_i;
    dirty_v  = elig & sel_dir_valid_i & sel_dir_dirty_i;

    cand_en  = (mode_i == ModeRandom) || (mode_i == ModeRoundRobin);
    cand_idx = (mode_i == ModeRandom) ? lfsr_q[IdxW-1:0] : ptr_q[sel_set_i];
    cand_oh  = '0;
    cand_oh[cand_idx] = 1'b1;

    victim      = '0;
    from_unused = 1'b0;
    if (|unused_v) begin
      victim      = first_oh(unused_v);
      from_unused = 1'b1;
    end else if (cand_en && |(cand_oh & elig & sel_dir_valid_i)) begin
      victim = cand_oh;
    end else if (|clean_v) begin
      victim = first_oh(clean_v);
    end else if (|dirty_v) begin
      victim = first_oh(dirty_v);
    end
  end

  assign sel_victim_way_o  = victim;
  assign sel_none_o        = ~|victim;
  assign sel_dirty_o       = |(victim & sel_dir_valid_i & sel_dir_dirty_i);
  assign dirty_evict_cnt_o = cnt_q;

  // Filling an unused way consumes no policy state, so neither LFSR nor pointer advances.
  always_comb begin
    accept  = sel_victim_i & ~sel_none_o;
    lfsr_fb = ^(lfsr_q & Taps);
    lfsr_d  = (accept && !from_unused) ? {lfsr_q[LFSR_WIDTH-2:0], lfsr_fb} : lfsr_q;
    ptr_we  = accept && !from_unused && (mode_i == ModeRoundRobin);
    ptr_d   = oh_to_idx(victim) + way_idx_t'(1);
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (accept && sel_dirty_o && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= LFSR_WIDTH'(1);
      cnt_q  <= '0;
      for (int s = 0; s < SETS; s++) begin
        ptr_q[s] <= '0;
      end
    end else begin
      lfsr_q <= lfsr_d;
      cnt_q  <= cnt_d;
      if (ptr_we) ptr_q[sel_set_i] <= ptr_d;
    end
  end

endmodule

// File: doc/hpdcache_victim_sel_multi.md
# hpdcache_victim_sel_multi

Runtime-configurable victim-way selector for the HPDcache miss/refill path. It generalises the pseudo-random replacement policy with a selectable mode (pseudo-random, per-set round-robin, fixed-priority), a way-lock mask, a configurable LFSR width, and a saturating dirty-eviction counter. It sits next to the directory. It takes per-way valid/dirty/fetch state for the indexed set and returns a one-hot victim in the same cycle, updating its internal state at the next clock edge.

## Interface
- SETS, 128, number of sets; ≥2.
- WAYS, 4, number of ways; power of two, 2..32.
- LFSR_WIDTH, 8, random generator width; one of 8, 16, 32; must be ≥ log2(WAYS).
- CNT_WIDTH, 16, dirty-eviction counter width.

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- mode_i  in  2  policy: 0 RANDOM, 1 ROUND_ROBIN, 2/3 FIRST.
- sel_victim_i  in  1  selection request; state updates only when high.
- sel_set_i  in  log2(SETS)  indexed set.
- sel_dir_valid_i / sel_dir_dirty_i / sel_dir_fetch_i  in  WAYS each  per-way directory state.
- lock_i  in  WAYS  locked ways; never selected.
- cnt_clr_i  in  1  clears the dirty-eviction counter.
- sel_victim_way_o  out  WAYS  one-hot victim; '0 when none is eligible.
- sel_none_o  out  1  no eligible way.
- sel_dirty_o  out  1  selected way is valid and dirty; the requester must write it back.
- dirty_evict_cnt_o  out  CNT_WIDTH  count of dirty selections.

## Operation
- Eligibility: e = ~fetch & ~lock.
  - unused = e & ~valid
  - clean = e & valid & ~dirty
  - dirty = e & valid & dirty
- Policy candidate index c:
  - RANDOM: c = lfsr[log2(WAYS)-1:0].
  - ROUND_ROBIN: c = ptr[sel_set_i].
  - FIRST: no candidate.
- Selection priority:
  1. Lowest-index unused way.
  2. Way c, if it is eligible and valid.
  3. Lowest-index clean way.
  4. Lowest-index dirty way.
  5. Otherwise '0 with sel_none_o=1.
- Outputs are purely combinational and independent of sel_victim_i.
- A selection is "accepted" when sel_victim_i=1 and sel_none_o=0. State updates only on an accepted selection:
  - LFSR: shifts once, in every mode, when the selection did not come from the unused category.
  - ROUND_ROBIN pointer: ptr[sel_set_i] <= (index of selected way + 1) mod WAYS, only when mode_i=1 and the selection did not come from the unused category.
  - Counter: increments when sel_dirty_o=1. It saturates at all-ones and does not wrap.
- LFSR is Fibonacci, shifting left: next = {lfsr[W-2:0], fb}, where fb is the XOR of bits (tap−1).
  - W=8: taps 8,6,5,4.
  - W=16: taps 16,14,13,11.
  - W=32: taps 32,22,2,1.
- Pointer storage: SETS × log2(WAYS) flops. Pointers for other sets are untouched.
- Mode changes take effect immediately. Pointers and LFSR state are retained across mode changes.
- cnt_clr_i takes priority over an increment in the same cycle; the counter becomes 0.

## Timing
- Selection latency: 0 cycles (combinational). State is visible the cycle after acceptance.
- Back-to-back selections to the same set in consecutive cycles see the updated pointer or LFSR on the second cycle.
- Reset values: LFSR = 1, all ptr = 0, counter = 0.
  - dirty_evict_cnt_o = 0 from the first cycle after reset.
  - Selection outputs follow the inputs combinationally, including during reset.
- Reset asserted together with sel_victim_i: reset wins and no update is applied.
- Reset mid-sequence: the random and round-robin sequences restart from the reset values.
- All-locked or all-fetching set: sel_none_o=1 and no state change, even if sel_victim_i=1.

## Test plan
- **RANDOM sequence.** WAYS=4, LFSR=8, all valid and clean, 4 back-to-back selections → victims 0010, 0100, 0001, 0001; LFSR then equals 0x11.
- **ROUND_ROBIN per set.** All valid and clean; set 5 is selected 3 times → 0001, 0010, 0100. Then set 6 is selected → 0001. Set 5 again → 1000, then wraps to 0001.
- **Lock and unused priority.**
  - ROUND_ROBIN with ptr=0, lock_i=0001 → 0010 selected, and ptr becomes 2.
  - Way 2 invalid → 0100 selected and ptr stays unchanged.
- **Dirty fallback.** Ways 0–2 fetching, way 3 valid and dirty → 1000, sel_dirty_o=1, counter goes 0→1. With cnt_clr_i held in the same cycle, the counter reads 0 instead.
- **No eligible way.** All fetching, sel_victim_i=1 → way vector 0000, sel_none_o=1; LFSR, pointers and counter are unchanged.
- **Saturation and reset.**
  - CNT_WIDTH=4: 17 dirty selections → counter holds 15.
  - rst_i asserted mid-sequence → counter reads 0, ptr reads 0, and the next RANDOM victim is 0010.
